// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention output collector: states, beat payload, address packing.
package attn_pkg;

  localparam int unsigned LANES   = 4;
  localparam int unsigned GROUPS  = 32;
  localparam int unsigned ROWS    = 4;
  localparam int unsigned ROW_W   = $clog2(ROWS);
  localparam int unsigned GROUP_W = $clog2(GROUPS);
  localparam int unsigned ADDR_W  = $clog2(GROUPS * ROWS);
  localparam int unsigned DATA_W  = LANES * 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [ROW_W-1:0]   row;
    logic [GROUP_W-1:0] group;
    logic [DATA_W-1:0]  data;
  } beat_t;

  // SRAM address layout: group in the upper bits, row in the lower bits
  function automatic logic [ADDR_W-1:0] pack_addr(input logic [GROUP_W-1:0] group,
                                                  input logic [ROW_W-1:0]   row);
    return {group, row};
  endfunction

endpackage

// File: rtl/attn_out_fifo.sv
// Synchronous beat FIFO with flush; head is presented combinationally for the write arbiter.
module attn_out_fifo
  import attn_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  beat_t                    din,
  output beat_t                    head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  beat_t         mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_nxt;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO only lands when the head leaves in the same cycle
  assign do_pop  = !clear && pop && !empty;
  assign do_push = !clear && push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/attn_out_collector.sv
// Buffers the attention core output stream and writes it to the output SRAM,
// sharing the single SRAM port with host readback.
module attn_out_collector
  import attn_pkg::*;
#(
  parameter  int unsigned READ_LAT   = 2,
  parameter  int unsigned FIFO_DEPTH = 4,
  parameter  int unsigned N_ENTRIES  = 128,
  localparam int unsigned CNT_W      = $clog2(N_ENTRIES) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [ROW_W-1:0]   in_row,
  input  logic [GROUP_W-1:0] in_group,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_done,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_web,
  output logic [DATA_W-1:0]  mem_din,
  input  logic [DATA_W-1:0]  mem_dout,
  input  logic               rd_req,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic               rd_ack,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               complete,
  output logic [CNT_W-1:0]   wr_count,
  output logic               overflow
);

  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FCW-1:0] HI_WATER = FCW'(FIFO_DEPTH - 1);

  state_t          state;
  beat_t           push_beat;
  beat_t           fifo_head_c;
  logic [FCW-1:0]  fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            wr_sel;
  logic            rd_sel;
  logic [READ_LAT-1:0] rd_pipe;

  assign push_beat = '{row: in_row, group: in_group, data: in_data};

  attn_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start),
    .push   (fifo_push),
    .pop    (wr_sel),
    .din    (push_beat),
    .head_c (fifo_head_c),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Writes win near full so the no-backpressure stream cannot be starved by host reads;
  // the cycle of start flushes the FIFO, so nothing is written then.
  always_comb begin
    fifo_push = (state == COLLECT) && in_valid && !start;
    wr_sel    = !start && ((fifo_count >= HI_WATER) || (!fifo_empty && !rd_req));
  end

  assign rd_sel = !wr_sel && rd_req;

  // Pass control; busy/complete are registered alongside the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      complete <= 1'b0;
    end else if (start) begin
      state    <= COLLECT;
      busy     <= 1'b1;
      complete <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (in_done) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state    <= DONE;
            busy     <= 1'b0;
            complete <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // SRAM port and pass statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      mem_web  <= 1'b1;
      mem_din  <= '0;
      wr_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_sel) begin
        mem_addr <= pack_addr(fifo_head_c.group, fifo_head_c.row);
        mem_din  <= fifo_head_c.data;
        mem_web  <= 1'b0;
      end else if (rd_sel) begin
        mem_addr <= rd_addr;
        mem_web  <= 1'b1;
      end else begin
        mem_web  <= 1'b1;
      end

      if (start) begin
        wr_count <= '0;
      end else if (wr_sel && (wr_count != '1)) begin
        wr_count <= wr_count + 1'b1;
      end

      if (start) begin
        overflow <= 1'b0;
      end else if (fifo_push && fifo_full && !wr_sel) begin
        overflow <= 1'b1;
      end
    end
  end

  // rd_pipe[k] is high k cycles after the read address went out; stage 0 doubles as rd_ack
  assign rd_ack = rd_pipe[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe[0] <= rd_sel;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      rd_valid <= rd_pipe[READ_LAT-1];
      if (rd_pipe[READ_LAT-1]) begin
        rd_data <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_attn_out_collector.sv
// Self-checking bench for attn_out_collector: directed passes plus randomized traffic,
// compared cycle by cycle against a queue-based reference model and a behavioural SRAM.
module tb_attn_out_collector;
  import attn_pkg::*;

  localparam int RL    = 2;
  localparam int DEPTH = 4;

  localparam int M_IDLE    = 0;
  localparam int M_COLLECT = 1;
  localparam int M_DRAIN   = 2;
  localparam int M_DONE    = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         in_valid;
  logic [1:0]   in_row;
  logic [4:0]   in_group;
  logic [127:0] in_data;
  logic         in_done;
  logic [6:0]   mem_addr;
  logic         mem_web;
  logic [127:0] mem_din;
  logic [127:0] mem_dout;
  logic         rd_req;
  logic [6:0]   rd_addr;
  logic         rd_ack;
  logic         rd_valid;
  logic [127:0] rd_data;
  logic         busy;
  logic         complete;
  logic [7:0]   wr_count;
  logic         overflow;

  always #5 clk = ~clk;

  attn_out_collector #(.READ_LAT(RL), .FIFO_DEPTH(DEPTH), .N_ENTRIES(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_row(in_row),
    .in_group(in_group), .in_data(in_data), .in_done(in_done), .mem_addr(mem_addr),
    .mem_web(mem_web), .mem_din(mem_din), .mem_dout(mem_dout), .rd_req(rd_req),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .complete(complete), .wr_count(wr_count), .overflow(overflow)
  );

  // Synchronous SRAM: data for the address driven in cycle M appears in cycle M+1
  logic [127:0] sram [128];
  always @(posedge clk) begin
    if (!mem_web) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  // Reference model state
  typedef struct { int due; logic [127:0] d; } rd_t;
  beat_t        q[$];
  rd_t          pend[$];
  logic [127:0] ref_mem [128];
  logic [127:0] obs_q[$];
  int           m_state;
  int           cyc;
  logic         stall;
  logic         e_mem_web;
  logic [6:0]   e_mem_addr;
  logic [127:0] e_mem_din;
  logic         e_rd_ack;
  logic         e_rd_valid;
  logic [127:0] e_rd_data;
  int           e_wr_count;
  logic         e_overflow;

  int vectors;
  int miscompares;

  function automatic logic [127:0] pat(input int g, input int r);
    logic [127:0] v;
    v = '0;
    for (int l = 0; l < 4; l++) v[l*32 +: 32] = {8'(g), 8'(r), 16'(l)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    m_state    = M_IDLE;
    e_mem_web  = 1'b1;
    e_mem_addr = '0;
    e_mem_din  = '0;
    e_rd_ack   = 1'b0;
    e_rd_valid = 1'b0;
    e_rd_data  = '0;
    e_wr_count = 0;
    e_overflow = 1'b0;
  endtask

  // One clock edge of the specified behaviour, from the inputs present at that edge
  task automatic model_edge();
    bit    wr;
    bit    rd;
    int    sz0;
    beat_t b;
    rd_t   p;
    cyc++;
    sz0 = q.size();
    wr  = !start && !stall && (sz0 >= DEPTH - 1 || (sz0 > 0 && !rd_req));
    rd  = !wr && rd_req;
    e_rd_ack   = rd;
    e_rd_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_rd_valid = 1'b1;
      e_rd_data  = pend[0].d;
      void'(pend.pop_front());
    end
    if (rd) begin
      p.due = cyc + RL;
      p.d   = ref_mem[rd_addr];
      pend.push_back(p);
      e_mem_addr = rd_addr;
    end
    e_mem_web = !wr;
    if (wr) begin
      b = q.pop_front();
      ref_mem[{b.group, b.row}] = b.data;
      e_mem_addr = {b.group, b.row};
      e_mem_din  = b.data;
      if (e_wr_count < 255) e_wr_count++;
    end
    if (start) begin
      q.delete();
      e_wr_count = 0;
      e_overflow = 1'b0;
    end else if (m_state == M_COLLECT && in_valid) begin
      if (q.size() < DEPTH) begin
        b.row = in_row; b.group = in_group; b.data = in_data;
        q.push_back(b);
      end else begin
        e_overflow = 1'b1;
      end
    end
    if (start) m_state = M_COLLECT;
    else if (m_state == M_COLLECT && in_done) m_state = M_DRAIN;
    else if (m_state == M_DRAIN && sz0 == 0) m_state = M_DONE;
  endtask

  task automatic check_all();
    chk("mem_web", 128'(mem_web), 128'(e_mem_web));
    if (!e_mem_web || e_rd_ack) chk("mem_addr", 128'(mem_addr), 128'(e_mem_addr));
    if (!e_mem_web) chk("mem_din", mem_din, e_mem_din);
    chk("rd_ack", 128'(rd_ack), 128'(e_rd_ack));
    chk("rd_valid", 128'(rd_valid), 128'(e_rd_valid));
    chk("rd_data", rd_data, e_rd_data);
    chk("busy", 128'(busy), 128'(m_state == M_COLLECT || m_state == M_DRAIN));
    chk("complete", 128'(complete), 128'(m_state == M_DONE));
    chk("wr_count", 128'(wr_count), 128'(e_wr_count));
    chk("overflow", 128'(overflow), 128'(e_overflow));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all();
    if (rd_valid) obs_q.push_back(rd_data);
  endtask

  task automatic beat(input int g, input int r, input logic [127:0] d);
    in_valid = 1'b1;
    in_group = 5'(g);
    in_row   = 2'(r);
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_pass();
    in_done = 1'b1;
    step();
    in_done = 1'b0;
    for (int i = 0; i < 40 && !complete; i++) step();
    chk("pass_complete", 128'(complete), 128'(1));
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; stall = 1'b0;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_row = '0; in_group = '0;
    in_data = '0; in_done = 1'b0; rd_req = 1'b0; rd_addr = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    model_reset();

    // Reset values
    step();
    step();
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mem_din", mem_din, 128'(0));
    rst_n = 1'b1;
    step();

    // Full ordered pass with the pattern payload
    pulse_start();
    for (int g = 0; g < 32; g++)
      for (int r = 0; r < 4; r++) beat(g, r, pat(g, r));
    finish_pass();
    chk("p1_wr_count", 128'(wr_count), 128'(128));
    chk("p1_overflow", 128'(overflow), 128'(0));

    // Back-to-back readback of 0,1,127 then every entry against its pattern
    obs_q.delete();
    rd_req = 1'b1;
    rd_addr = 7'd0;   step(); chk("rb_ack0", 128'(rd_ack), 128'(1));
    rd_addr = 7'd1;   step(); chk("rb_ack1", 128'(rd_ack), 128'(1));
    rd_addr = 7'd127; step(); chk("rb_ack127", 128'(rd_ack), 128'(1));
    rd_req = 1'b0;
    repeat (3) step();
    chk("rb_count3", 128'(obs_q.size()), 128'(3));
    if (obs_q.size() == 3) begin
      chk("rb_data0", obs_q[0], pat(0, 0));
      chk("rb_data1", obs_q[1], pat(0, 1));
      chk("rb_data127", obs_q[2], pat(31, 3));
    end
    obs_q.delete();
    for (int a = 0; a < 128; a++) begin
      rd_req = 1'b1; rd_addr = 7'(a); step();
    end
    rd_req = 1'b0;
    repeat (4) step();
    chk("rb_all_count", 128'(obs_q.size()), 128'(128));
    for (int a = 0; a < 128 && a < obs_q.size(); a++) chk("rb_all_data", obs_q[a], pat(a >> 2, a & 3));

    // Reads held high while streaming: writes must keep up
    pulse_start();
    rd_req = 1'b1;
    for (int n = 0; n < 128; n++) begin
      rd_addr = 7'($urandom_range(127));
      beat(n >> 2, n & 3, rnd128());
    end
    rd_req = 1'b0;
    finish_pass();
    chk("rdhold_wr_count", 128'(wr_count), 128'(128));
    chk("rdhold_overflow", 128'(overflow), 128'(0));

    // Write stall for 5 cycles while streaming forces drops
    pulse_start();
    for (int n = 0; n < 128; n++) begin
      if (n == 40) begin stall = 1'b1; force dut.wr_sel = 1'b0; end
      if (n == 45) begin stall = 1'b0; release dut.wr_sel; end
      beat(n >> 2, n & 3, pat(n >> 2, n & 3));
    end
    finish_pass();
    chk("ovf_sticky", 128'(overflow), 128'(1));
    chk("ovf_lost_beats", 128'(wr_count < 8'd128), 128'(1));
    pulse_start();
    chk("ovf_cleared", 128'(overflow), 128'(0));

    // Early done after 50 beats with random gaps, reads and data
    for (int n = 0; n < 50; n++) begin
      while ($urandom_range(3) == 0) begin
        rd_req = 1'($urandom_range(1)); rd_addr = 7'($urandom_range(127)); step();
      end
      rd_req = 1'($urandom_range(1)); rd_addr = 7'($urandom_range(127));
      beat(n >> 2, n & 3, rnd128());
    end
    rd_req = 1'b0;
    finish_pass();
    chk("early_wr_count", 128'(wr_count), 128'(50));

    // Restart mid-collect: beat alongside start is dropped and the FIFO flushed
    pulse_start();
    for (int n = 0; n < 10; n++) beat(n >> 2, n & 3, rnd128());
    start = 1'b1; in_valid = 1'b1; in_data = rnd128();
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("restart_wr_count", 128'(wr_count), 128'(0));
    chk("restart_fifo_empty", 128'(dut.fifo_count), 128'(0));
    finish_pass();
    chk("restart_final_count", 128'(wr_count), 128'(0));

    // Async reset mid-collect, then beats without start are ignored
    pulse_start();
    for (int n = 0; n < 20; n++) beat(n >> 2, n & 3, rnd128());
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_mem_web", 128'(mem_web), 128'(1));
    chk("arst_mem_addr", 128'(mem_addr), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) beat(n >> 2, n & 3, rnd128());
    chk("idle_ignored_count", 128'(wr_count), 128'(0));
    chk("idle_ignored_web", 128'(mem_web), 128'(1));
    pulse_start();
    for (int n = 0; n < 4; n++) beat(0, n, pat(0, n));
    finish_pass();
    chk("post_reset_count", 128'(wr_count), 128'(4));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
